nec_ir_tx: RTL and testbench

NEC-protocol infrared transmitter. It accepts a 32-bit command word over a valid/ready handshake from the button/command front end. It serialises the word as a standard NEC frame (leader, 32 data bits LSB first, stop burst) and modulates every mark with a 38 kHz carrier onto one GPIO pin. It also emits NEC repeat codes on request after a frame has been sent.

---
 rtl/nec_ir_tx.sv | 169 ++++++++++++++++
 tb/tb_nec_ir_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: serialises a 32-bit command (leader, LSB-first data, stop burst)
// or a repeat code, with a 38 kHz carrier gated by the mark envelope.
module nec_ir_tx #(
    parameter int unsigned UNIT_CYCLES    = 14063,
    parameter int unsigned CARRIER_PERIOD = 658,
    parameter int unsigned CARRIER_HIGH   = 219,
    parameter int unsigned FRAME_UNITS    = 192
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic [31:0] cmd,
    input  logic        valid,
    input  logic        repeat_req,
    output logic        ready,
    output logic        ir_envelope,
    output logic        ir_output
);

    localparam int unsigned CW = (CARRIER_PERIOD > 2) ? $clog2(CARRIER_PERIOD) : 1;

    localparam logic [13:0]   UNIT_LAST  = 14'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CAR_LAST   = CW'(CARRIER_PERIOD - 1);
    localparam logic [CW-1:0] CAR_HIGH   = CW'(CARRIER_HIGH);
    localparam logic [7:0]    FRAME_LAST = 8'(FRAME_UNITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    state_t        state, state_d;
    logic [31:0]   shreg, shreg_d;
    logic [4:0]    bit_idx, bit_idx_d;
    logic          rpt_mode, rpt_mode_d;
    logic          sent_flag, sent_flag_d;
    logic [13:0]   unit_ctr, unit_ctr_d;
    logic [4:0]    st_units, st_units_d;
    logic [7:0]    frame_units, frame_units_d;
    logic [CW-1:0] car_cnt, car_cnt_d;
    logic          env_q, env_d;
    logic          out_q, out_d;
    logic          tick;
    logic          cur_mark;

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_idx     <= '0;
            rpt_mode    <= 1'b0;
            sent_flag   <= 1'b0;
            unit_ctr    <= '0;
            st_units    <= '0;
            frame_units <= '0;
            car_cnt     <= '0;
            env_q       <= 1'b0;
            out_q       <= 1'b0;
        end else begin
            state       <= state_d;
            shreg       <= shreg_d;
            bit_idx     <= bit_idx_d;
            rpt_mode    <= rpt_mode_d;
            sent_flag   <= sent_flag_d;
            unit_ctr    <= unit_ctr_d;
            st_units    <= st_units_d;
            frame_units <= frame_units_d;
            car_cnt     <= car_cnt_d;
            env_q       <= env_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        state_d       = state;
        shreg_d       = shreg;
        bit_idx_d     = bit_idx;
        rpt_mode_d    = rpt_mode;
        sent_flag_d   = sent_flag;
        unit_ctr_d    = '0;
        st_units_d    = '0;
        frame_units_d = '0;
        tick          = (unit_ctr == UNIT_LAST);

        // Unit timing only advances inside a frame; IDLE parks every counter at zero.
        if (state != IDLE) begin
            unit_ctr_d    = tick ? '0 : unit_ctr + 14'd1;
            st_units_d    = tick ? st_units + 5'd1 : st_units;
            frame_units_d = tick ? frame_units + 8'd1 : frame_units;
        end

        case (state)
            IDLE: begin
                if (valid) begin
                    shreg_d    = cmd;
                    bit_idx_d  = '0;
                    rpt_mode_d = 1'b0;
                    state_d    = LEAD_MARK;
                end else if (repeat_req && sent_flag) begin
                    bit_idx_d  = '0;
                    rpt_mode_d = 1'b1;
                    state_d    = LEAD_MARK;
                end
            end
            LEAD_MARK: begin
                if (tick && st_units == 5'd15) begin
                    st_units_d = '0;
                    state_d    = LEAD_SPACE;
                end
            end
            LEAD_SPACE: begin
                if (tick && st_units == (rpt_mode ? 5'd3 : 5'd7)) begin
                    st_units_d = '0;
                    state_d    = rpt_mode ? STOP_MARK : BIT_MARK;
                end
            end
            BIT_MARK: begin
                if (tick) begin
                    st_units_d = '0;
                    state_d    = BIT_SPACE;
                end
            end
            BIT_SPACE: begin
                if (tick && st_units == (shreg[0] ? 5'd2 : 5'd0)) begin
                    st_units_d = '0;
                    shreg_d    = {1'b0, shreg[31:1]};
                    bit_idx_d  = bit_idx + 5'd1;
                    state_d    = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK: begin
                if (tick) begin
                    st_units_d  = '0;
                    sent_flag_d = 1'b1;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (tick && frame_units == FRAME_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the first mark cycle already sees carrier count 0.
    always_comb begin
        cur_mark = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
        env_d    = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);
        if (env_d && !cur_mark) begin
            car_cnt_d = '0;
        end else if (car_cnt == CAR_LAST) begin
            car_cnt_d = '0;
        end else begin
            car_cnt_d = car_cnt + CW'(1);
        end
        out_d = env_d && (car_cnt_d < CAR_HIGH);
    end

    assign ready       = (state == IDLE);
    assign ir_envelope = env_q;
    assign ir_output   = out_q;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Randomised bench for nec_ir_tx with scaled timing; expected waveforms come from a unit-level
// frame description expanded to cycles.
module tb_nec_ir_tx;

    localparam int unsigned UC = 20;
    localparam int unsigned CP = 6;
    localparam int unsigned CH = 2;
    localparam int unsigned FU = 192;

    logic        clk25 = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic        valid;
    logic        repeat_req;
    logic        ready;
    logic        ir_envelope;
    logic        ir_output;

    int n_checks = 0;
    int n_errors = 0;

    nec_ir_tx #(
        .UNIT_CYCLES   (UC),
        .CARRIER_PERIOD(CP),
        .CARRIER_HIGH  (CH),
        .FRAME_UNITS   (FU)
    ) dut (
        .clk25      (clk25),
        .rst        (rst),
        .cmd        (cmd),
        .valid      (valid),
        .repeat_req (repeat_req),
        .ready      (ready),
        .ir_envelope(ir_envelope),
        .ir_output  (ir_output)
    );

    always #5 clk25 = ~clk25;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {29'd0, ready, ir_envelope, ir_output};
    endfunction

    // Envelope per NEC unit for a whole frame slot.
    function automatic void build_units(input logic [31:0] c, input bit rpt, output bit u[FU]);
        bit q[$];
        for (int i = 0; i < 16; i++) q.push_back(1'b1);
        for (int i = 0; i < (rpt ? 4 : 8); i++) q.push_back(1'b0);
        if (!rpt) begin
            for (int b = 0; b < 32; b++) begin
                q.push_back(1'b1);
                for (int i = 0; i < (c[b] ? 3 : 1); i++) q.push_back(1'b0);
            end
        end
        q.push_back(1'b1);
        while (q.size() < FU) q.push_back(1'b0);
        for (int i = 0; i < int'(FU); i++) u[i] = q[i];
    endfunction

    // Called #1 after a posedge with the DUT idle. Returns either after the idle cycle
    // that follows the frame, or at cycle abort_at (relative to T+1) if abort_at >= 0.
    task automatic send(input string name, input logic [31:0] c, input bit use_valid,
                        input bit use_rpt, input bit hold, input bit scramble, input int abort_at);
        bit u[FU];
        bit e, o, prev_e, prev_o;
        int ms, edges;
        build_units(c, !use_valid, u);
        cmd = c;
        valid = use_valid;
        repeat_req = use_rpt;
        @(posedge clk25);
        #1;
        if (!hold) begin
            valid = 1'b0;
            repeat_req = 1'b0;
        end
        prev_e = 1'b0;
        prev_o = 1'b0;
        ms = 0;
        edges = 0;
        for (int k = 0; k < int'(FU * UC); k++) begin
            if (k == abort_at) return;
            e = u[k / int'(UC)];
            if (e && !prev_e) ms = k;
            o = e && (((k - ms) % int'(CP)) < int'(CH));
            check($sformatf("%s k=%0d", name, k), obs(), {29'd0, 1'b0, e, o});
            if (ir_output && !prev_o) edges++;
            prev_o = ir_output;
            prev_e = e;
            if (k == int'(16 * UC) - 1)
                check({name, " lead_edges"}, edges, (16 * UC + CP - 1) / CP);
            if (scramble && (k % 500 == 250)) cmd = $urandom;
            @(posedge clk25);
            #1;
        end
        check({name, " ready_back"}, obs(), 32'h4);
    endtask

    task automatic idle_run(input string name, input int n, input bit rq);
        repeat_req = rq;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s i=%0d", name, i), obs(), 32'h4);
            @(posedge clk25);
            #1;
        end
        repeat_req = 1'b0;
    endtask

    initial begin
        logic [31:0] c;
        int bit10;
        rst = 1'b1;
        cmd = '0;
        valid = 1'b0;
        repeat_req = 1'b0;
        #1;
        check("reset", obs(), 32'h4);
        repeat (3) @(posedge clk25);
        @(negedge clk25);
        rst = 1'b0;
        @(posedge clk25);
        #1;

        idle_run("idle", 1000, 1'b0);
        idle_run("rpt_nosent", 100, 1'b1);

        send("zero", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        send("edge", 32'h8000_0001, 1'b1, 1'b0, 1'b0, 1'b1, -1);

        // Held repeat request: the second repeat starts from the first idle cycle.
        send("rpt1", 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        send("rpt2", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, -1);

        c = $urandom;
        send("rand1", c, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        c = $urandom;
        send("rand2", c, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        c = $urandom;
        send("both", c, 1'b1, 1'b1, 1'b0, 1'b0, -1);

        // Abort in the middle of bit 10's mark.
        c = $urandom;
        bit10 = 24;
        for (int b = 0; b < 10; b++) bit10 += c[b] ? 4 : 2;
        send("abort", c, 1'b1, 1'b0, 1'b0, 1'b0, bit10 * int'(UC) + int'(UC) / 2);
        check("abort pre", {31'd0, ir_envelope}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("abort rst", obs(), 32'h4);
        repeat (2) @(posedge clk25);
        @(negedge clk25);
        rst = 1'b0;
        @(posedge clk25);
        #1;
        idle_run("post_rst", 20, 1'b0);
        idle_run("rpt_cleared", 100, 1'b1);

        c = $urandom;
        send("restart", c, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
